// File: rtl/mux8_sched_pkg.sv
// Shared constants and the rotating-priority search used by the 8-source scheduler.
package mux8_sched_pkg;

  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Returns {found, index}: the first set request starting at ptr and wrapping modulo 8.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                             input logic [SEL_W-1:0] ptr);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      j = ptr + SEL_W'(i);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux8_sel.sv
// Pure combinational 8:1 single-bit mux.
module mux8_sel
  import mux8_sched_pkg::*;
(
  input  logic [N_SRC-1:0] din,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = din[sel];

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of a shared 8:1 bit mux: bounded bursts, registered output with valid strobe.
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] din,
  output logic [N_SRC-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y,
  output logic             y_valid
);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             yv_q, yv_d;

  logic             mux_bit;
  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] win;
  logic             beat;
  logic             last_beat;
  logic             rel;

  mux8_sel u_mux (
    .din (din),
    .sel (sel_q),
    .y   (mux_bit)
  );

  assign beat      = (state_q == GRANT) && req[sel_q];
  assign last_beat = beat && (cnt_q == CNT_W'(MAX_BEATS - 1));
  assign rel       = (state_q == GRANT) && (!req[sel_q] || last_beat);

  // On release the search starts just past the old owner, so it ranks last.
  always_comb begin
    pick_ptr     = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
    {found, win} = rr_pick(req, pick_ptr);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    if (beat) begin
      y_d   = mux_bit;
      yv_d  = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q == IDLE) || rel) begin
      if (rel) begin
        ptr_d = sel_q + SEL_W'(1);
      end
      if (found) begin
        state_d    = GRANT;
        sel_d      = win;
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        cnt_d      = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == GRANT);
  assign y       = y_q;
  assign y_valid = yv_q;

endmodule
